// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: walks each MIPS-subset instruction through IF/ID/EXE/MEM/WB and drives the datapath control lines.
// Latency: 2 (j), 3 (branches), 4 (ALU ops, sw) or 5 (lw) cycles per instruction; outputs are combinational from state/Opcode.
// Backpressure: none, the sequencer free-runs every cycle; HALT holds until Reset is asserted.
module multi_cycle_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        sign,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        PCWre,
    output logic        RegWre,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic        DBDataSrc,
    output logic        nRD,
    output logic        nWR,
    output logic [1:0]  PCSrc,
    output logic [3:0]  state,
    output logic [15:0] inst_count,
    output logic        illegal
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_BGTZ = 6'b110010;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Encoding matches the externally visible state numbering.
    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_WB_AL  = 4'd3,
        ST_EXE_BR = 4'd4,
        ST_EXE_LS = 4'd5,
        ST_MEM    = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LS,
        CL_BR,
        CL_JUMP,
        CL_HALT,
        CL_ILLEGAL
    } opclass_t;

    // ALU-side controls that are set up in EXE and held through write-back.
    typedef struct packed {
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [2:0] aluOp;
    } aluCtrl_t;

    state_t   stateQ;
    state_t   stateNxt;
    opclass_t opClass;
    aluCtrl_t aluCtrl;
    logic     isRType;
    logic     isStore;
    logic     brTaken;

    assign isStore = (Opcode == OP_SW);

    // Classify the opcode and derive the ALU controls for ALU-class instructions.
    always_comb begin
        opClass = CL_ILLEGAL;
        aluCtrl = '0;
        isRType = 1'b0;
        case (Opcode)
            OP_ADD: begin
                opClass       = CL_ALU;
                aluCtrl.aluOp = ALU_ADD;
                isRType       = 1'b1;
            end
            OP_ADDI: begin
                opClass         = CL_ALU;
                aluCtrl.aluOp   = ALU_ADD;
                aluCtrl.aluSrcB = 1'b1;
                aluCtrl.extSel  = 1'b1;
            end
            OP_SUB: begin
                opClass       = CL_ALU;
                aluCtrl.aluOp = ALU_SUB;
                isRType       = 1'b1;
            end
            OP_ORI: begin
                // Logical immediate is zero-extended.
                opClass         = CL_ALU;
                aluCtrl.aluOp   = ALU_OR;
                aluCtrl.aluSrcB = 1'b1;
            end
            OP_AND: begin
                opClass       = CL_ALU;
                aluCtrl.aluOp = ALU_AND;
                isRType       = 1'b1;
            end
            OP_OR: begin
                opClass       = CL_ALU;
                aluCtrl.aluOp = ALU_OR;
                isRType       = 1'b1;
            end
            OP_SLL: begin
                opClass         = CL_ALU;
                aluCtrl.aluOp   = ALU_SLL;
                aluCtrl.aluSrcA = 1'b1;
                isRType         = 1'b1;
            end
            OP_SLT: begin
                opClass       = CL_ALU;
                aluCtrl.aluOp = ALU_SLT;
                isRType       = 1'b1;
            end
            OP_SW, OP_LW:            opClass = CL_LS;
            OP_BEQ, OP_BNE, OP_BGTZ: opClass = CL_BR;
            OP_J:                    opClass = CL_JUMP;
            OP_HALT:                 opClass = CL_HALT;
            default:                 opClass = CL_ILLEGAL;
        endcase
    end

    // Branch decision from the ALU flags of the compare done in EXE_BR.
    always_comb begin
        brTaken = 1'b0;
        case (Opcode)
            OP_BEQ:  brTaken = zero;
            OP_BNE:  brTaken = ~zero;
            OP_BGTZ: brTaken = ~sign & ~zero;
            default: brTaken = 1'b0;
        endcase
    end

    // Next-state selection and datapath control outputs for the current state.
    always_comb begin
        stateNxt  = stateQ;
        IRWre     = 1'b0;
        InsMemRW  = 1'b1;
        PCWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        DBDataSrc = 1'b0;
        nRD       = 1'b1;
        nWR       = 1'b1;
        PCSrc     = PC_SEQ;
        case (stateQ)
            ST_IF: begin
                IRWre    = 1'b1;
                stateNxt = ST_ID;
            end
            ST_ID: begin
                case (opClass)
                    CL_ALU:  stateNxt = ST_EXE_AL;
                    CL_LS:   stateNxt = ST_EXE_LS;
                    CL_BR:   stateNxt = ST_EXE_BR;
                    CL_JUMP: begin
                        // Jump retires straight out of decode.
                        PCWre    = 1'b1;
                        PCSrc    = PC_JUMP;
                        stateNxt = ST_IF;
                    end
                    default: stateNxt = ST_HALT;
                endcase
            end
            ST_EXE_AL: begin
                ALUSrcA  = aluCtrl.aluSrcA;
                ALUSrcB  = aluCtrl.aluSrcB;
                ExtSel   = aluCtrl.extSel;
                ALUOp    = aluCtrl.aluOp;
                stateNxt = ST_WB_AL;
            end
            ST_WB_AL: begin
                // ALU controls held so the result stays stable while it is written.
                ALUSrcA  = aluCtrl.aluSrcA;
                ALUSrcB  = aluCtrl.aluSrcB;
                ExtSel   = aluCtrl.extSel;
                ALUOp    = aluCtrl.aluOp;
                RegWre   = 1'b1;
                RegDst   = isRType;
                PCWre    = 1'b1;
                stateNxt = ST_IF;
            end
            ST_EXE_LS: begin
                ALUSrcB  = 1'b1;
                ExtSel   = 1'b1;
                stateNxt = ST_MEM;
            end
            ST_MEM: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (isStore) begin
                    nWR      = 1'b0;
                    PCWre    = 1'b1;
                    stateNxt = ST_IF;
                end else begin
                    nRD      = 1'b0;
                    stateNxt = ST_WB_LD;
                end
            end
            ST_WB_LD: begin
                // Read kept asserted so load data is valid through the register write.
                ALUSrcB   = 1'b1;
                ExtSel    = 1'b1;
                nRD       = 1'b0;
                DBDataSrc = 1'b1;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                stateNxt  = ST_IF;
            end
            ST_EXE_BR: begin
                ALUOp    = ALU_SUB;
                ExtSel   = 1'b1;
                PCWre    = 1'b1;
                PCSrc    = brTaken ? PC_BRANCH : PC_SEQ;
                stateNxt = ST_IF;
            end
            ST_HALT: stateNxt = ST_HALT;
            default: stateNxt = ST_IF;
        endcase
    end

    // State register; reset aborts any instruction in flight and restarts at fetch.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateQ <= ST_IF;
        end else begin
            stateQ <= stateNxt;
        end
    end

    // Sticky illegal-opcode flag, set when an unknown opcode is decoded.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            illegal <= 1'b0;
        end else if (stateQ == ST_ID && opClass == CL_ILLEGAL) begin
            illegal <= 1'b1;
        end
    end

    // Retired-instruction counter, advances on the same edge as the PC and wraps.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            inst_count <= 16'd0;
        end else if (PCWre) begin
            inst_count <= inst_count + 16'd1;
        end
    end

    assign state = stateQ;

endmodule
